queue_out_arbiter: RTL and testbench

- Parametrised successor to the two-queue output select in the QoS queue set.
- Arbitrates NUM_Q first-word-fall-through queues onto one output word stream, one packet at a time. Grant is held until end-of-packet.
- Mode is run-time selectable: strict priority or packet-weighted round robin.
- Sits between the queue set and the egress datapath. Provides a registered output with valid/ready backpressure.

---
 rtl/queue_out_arbiter.sv | 149 ++++++++++++++
 tb/tb_queue_out_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_out_arbiter.sv
// Packet-granular arbiter draining NUM_Q FWFT queues onto one registered valid/ready stream.
// Grant is chosen by strict priority or packet-weighted round robin and held until end-of-packet.
module queue_out_arbiter #(
    parameter int NUM_Q    = 4,
    parameter int DATA_W   = 32,
    parameter int WEIGHT_W = 4,
    localparam int QW      = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      arb_en,
    input  logic                      arb_mode,
    input  logic [NUM_Q*WEIGHT_W-1:0] queue_weights,
    input  logic [NUM_Q-1:0]          queue_empty,
    input  logic [NUM_Q*DATA_W-1:0]   queue_data,
    input  logic [NUM_Q-1:0]          queue_eop,
    output logic [NUM_Q-1:0]          queue_rd_en,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_eop,
    output logic                      out_valid,
    input  logic                      out_rdy,
    output logic [QW-1:0]             cur_queue
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              r_state;
    logic [QW-1:0]       r_cur;
    logic [QW-1:0]       r_ptr;
    logic [WEIGHT_W-1:0] r_credit;
    logic [DATA_W-1:0]   r_data_p1;
    logic                r_eop_p1;
    logic                r_vld_p1;

    state_t              w_state_nxt;
    logic [QW-1:0]       w_cur_nxt;
    logic [QW-1:0]       w_ptr_nxt;
    logic [WEIGHT_W-1:0] w_credit_nxt;
    logic [QW-1:0]       w_sp_idx;
    logic [QW-1:0]       w_rr_idx;
    logic                w_rr_hit;
    logic [QW:0]         w_sum;
    logic                w_any;
    logic                w_pop;
    logic                w_head_eop;

    logic [DATA_W-1:0]   w_data   [NUM_Q];
    logic [WEIGHT_W-1:0] w_weight [NUM_Q];

    for (genvar g = 0; g < NUM_Q; g++) begin : g_unpack
        assign w_data[g]   = queue_data[g*DATA_W +: DATA_W];
        assign w_weight[g] = queue_weights[g*WEIGHT_W +: WEIGHT_W];
    end

    // Credit left after the first packet of a new turn; a zero weight still earns one packet.
    function automatic logic [WEIGHT_W-1:0] credit_load(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? '0 : w - WEIGHT_W'(1);
    endfunction

    assign w_any      = |(~queue_empty);
    assign w_head_eop = queue_eop[r_cur];
    assign w_pop      = (r_state == XFER) && !queue_empty[r_cur] && (!r_vld_p1 || out_rdy);

    always_comb begin
        w_sp_idx = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            if (!queue_empty[i]) w_sp_idx = QW'(i);
        end
    end

    // Round-robin search starts after the pointer and wraps back onto it last.
    always_comb begin
        w_rr_idx = r_ptr;
        w_rr_hit = 1'b0;
        w_sum    = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            w_sum = {1'b0, r_ptr} + (QW+1)'(k);
            if (w_sum >= (QW+1)'(NUM_Q)) w_sum = w_sum - (QW+1)'(NUM_Q);
            if (!w_rr_hit && !queue_empty[w_sum[QW-1:0]]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = w_sum[QW-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        case (r_state)
            IDLE: begin
                if (arb_en && w_any) begin
                    w_state_nxt = XFER;
                    if (!arb_mode) begin
                        w_cur_nxt = w_sp_idx;
                    end else if (!queue_empty[r_ptr] && (r_credit != '0)) begin
                        w_cur_nxt    = r_ptr;
                        w_credit_nxt = r_credit - WEIGHT_W'(1);
                    end else begin
                        w_cur_nxt    = w_rr_idx;
                        w_ptr_nxt    = w_rr_idx;
                        w_credit_nxt = credit_load(w_weight[w_rr_idx]);
                    end
                end
            end
            XFER: begin
                if (w_pop && w_head_eop) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cur    <= '0;
            r_ptr    <= '0;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    // p1: popped head word registered towards the egress datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_p1 <= '0;
            r_eop_p1  <= 1'b0;
            r_vld_p1  <= 1'b0;
        end else if (w_pop) begin
            r_data_p1 <= w_data[r_cur];
            r_eop_p1  <= w_head_eop;
            r_vld_p1  <= 1'b1;
        end else if (out_rdy) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign queue_rd_en = w_pop ? (NUM_Q'(1) << r_cur) : '0;
    assign out_data    = r_data_p1;
    assign out_eop     = r_eop_p1;
    assign out_valid   = r_vld_p1;
    assign cur_queue   = r_cur;

endmodule

// File: tb/tb_queue_out_arbiter.sv
// Scoreboard bench for queue_out_arbiter: bench-side FWFT queue models feed the DUT,
// stimulus pushes expected words, a negedge monitor pops and compares accepted outputs.
module tb_queue_out_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         arb_en;
    logic         arb_mode;
    logic [15:0]  queue_weights;
    logic [3:0]   queue_empty;
    logic [127:0] queue_data;
    logic [3:0]   queue_eop;
    logic [3:0]   queue_rd_en;
    logic [31:0]  out_data;
    logic         out_eop;
    logic         out_valid;
    logic         out_rdy;
    logic [1:0]   cur_queue;

    queue_out_arbiter #(.NUM_Q(4), .DATA_W(32), .WEIGHT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .arb_en(arb_en), .arb_mode(arb_mode),
        .queue_weights(queue_weights), .queue_empty(queue_empty), .queue_data(queue_data),
        .queue_eop(queue_eop), .queue_rd_en(queue_rd_en), .out_data(out_data),
        .out_eop(out_eop), .out_valid(out_valid), .out_rdy(out_rdy), .cur_queue(cur_queue)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int cyc      = 0;
    logic [32:0] exp_q[$];
    int          acc_cyc[$];

    logic [32:0] mem [4][128];
    logic [6:0]  wp  [4];
    logic [6:0]  rp  [4];

    for (genvar g = 0; g < 4; g++) begin : g_model
        assign queue_empty[g]          = (rp[g] == wp[g]);
        assign queue_data[g*32 +: 32]  = mem[g][rp[g]][31:0];
        assign queue_eop[g]            = mem[g][rp[g]][32];
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n)            rp[g] <= wp[g];
            else if (queue_rd_en[g]) rp[g] <= rp[g] + 7'd1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input bit ok, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] q, input logic [7:0] id, input logic [7:0] w);
        return {6'd0, q, 8'd0, id, w};
    endfunction

    task automatic qpush(input logic [1:0] q, input logic [31:0] d, input logic e);
        mem[q][wp[q]] = {e, d};
        wp[q] = wp[q] + 7'd1;
    endtask

    task automatic pkt(input logic [1:0] q, input logic [7:0] id, input int len, input bit add_exp);
        logic [31:0] d;
        logic        e;
        for (int w = 1; w <= len; w++) begin
            d = mk(q, id, 8'(w));
            e = (w == len);
            qpush(q, d, e);
            if (add_exp) exp_q.push_back({e, d});
        end
    endtask

    task automatic expect_pkt(input logic [1:0] q, input logic [7:0] id, input int len);
        for (int w = 1; w <= len; w++) exp_q.push_back({(w == len), mk(q, id, 8'(w))});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check(nm, exp_q.size() == 0, exp_q.size(), 0);
        tick();
        tick();
    endtask

    // Monitor: legality of every pop and in-order comparison of every accepted word.
    always @(negedge clk) begin
        logic [32:0] e;
        if (reset_n) begin
            if (queue_rd_en != 4'd0)
                check("rd_en_legal",
                      $onehot(queue_rd_en) && (queue_rd_en == (4'b1 << cur_queue)) &&
                      ((queue_rd_en & queue_empty) == 4'd0),
                      queue_rd_en, 4'b1 << cur_queue);
            if (out_valid && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b0, {out_eop, out_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("scoreboard_word", {out_eop, out_data} == e, {out_eop, out_data}, e);
                    n_acc++;
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d pending expected 0", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;
        logic [31:0] held;
        for (int q = 0; q < 4; q++) wp[q] = 7'd0;
        reset_n       = 1'b0;
        arb_en        = 1'b0;
        arb_mode      = 1'b0;
        out_rdy       = 1'b1;
        queue_weights = 16'h3121;   // q3=3, q2=1, q1=2, q0=1
        repeat (3) tick();
        check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("rst_out_data",  out_data == 32'd0, out_data, 0);
        check("rst_out_eop",   out_eop == 1'b0, out_eop, 0);
        check("rst_rd_en",     queue_rd_en == 4'd0, queue_rd_en, 0);
        check("rst_cur_queue", cur_queue == 2'd0, cur_queue, 0);
        reset_n = 1'b1;
        tick();

        // Strict priority: queue 0 before queue 2, one idle cycle between packets.
        base = acc_cyc.size();
        pkt(2'd0, 8'd1, 3, 1'b1);
        pkt(2'd2, 8'd1, 3, 1'b1);
        arb_en = 1'b1;
        drain("strict_drain");
        if (acc_cyc.size() >= base + 6) begin
            check("strict_back_to_back", acc_cyc[base+2] - acc_cyc[base] == 2, acc_cyc[base+2] - acc_cyc[base], 2);
            check("strict_gap", acc_cyc[base+3] - acc_cyc[base+2] == 2, acc_cyc[base+3] - acc_cyc[base+2], 2);
        end else begin
            check("strict_word_count", 1'b0, acc_cyc.size() - base, 6);
        end

        // WRR weights {1,2,1,3}: grant order 0,1,1,2,3,3,3,0,1,1.
        arb_en   = 1'b0;
        arb_mode = 1'b1;
        pkt(2'd0, 8'd1, 1, 1'b1);
        pkt(2'd0, 8'd2, 1, 1'b0);
        arb_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (queue_rd_en[0]) seen = 1'b1;
            else tick();
        end
        check("wrr_first_grant_q0", seen, seen, 1);
        for (int k = 1; k <= 4; k++) pkt(2'd1, 8'(k), 1, 1'b0);
        pkt(2'd2, 8'd1, 1, 1'b0);
        for (int k = 1; k <= 3; k++) pkt(2'd3, 8'(k), 1, 1'b0);
        expect_pkt(2'd1, 8'd1, 1);
        expect_pkt(2'd1, 8'd2, 1);
        expect_pkt(2'd2, 8'd1, 1);
        expect_pkt(2'd3, 8'd1, 1);
        expect_pkt(2'd3, 8'd2, 1);
        expect_pkt(2'd3, 8'd3, 1);
        expect_pkt(2'd0, 8'd2, 1);
        expect_pkt(2'd1, 8'd3, 1);
        expect_pkt(2'd1, 8'd4, 1);
        drain("wrr_drain");

        // Backpressure mid-packet for 4 cycles.
        arb_mode = 1'b0;
        pkt(2'd1, 8'd5, 4, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check("bp_first_valid", seen, seen, 1);
        out_rdy = 1'b0;
        #1;
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            check("bp_rd_en_zero", queue_rd_en == 4'd0, queue_rd_en, 0);
            check("bp_valid_held", out_valid == 1'b1, out_valid, 1);
            check("bp_data_held", out_data == held, out_data, held);
            tick();
        end
        out_rdy = 1'b1;
        drain("bp_drain");

        // Underrun: queue 1 runs dry after word 2 of 4 while queue 3 waits.
        qpush(2'd1, mk(2'd1, 8'd6, 8'd1), 1'b0);
        qpush(2'd1, mk(2'd1, 8'd6, 8'd2), 1'b0);
        exp_q.push_back({1'b0, mk(2'd1, 8'd6, 8'd1)});
        exp_q.push_back({1'b0, mk(2'd1, 8'd6, 8'd2)});
        pkt(2'd3, 8'd6, 1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (rp[1] == wp[1]) seen = 1'b1;
            else tick();
        end
        check("ur_q1_dry", seen, seen, 1);
        for (int i = 0; i < 5; i++) begin
            check("ur_grant_held", cur_queue == 2'd1, cur_queue, 1);
            check("ur_no_pop", queue_rd_en == 4'd0, queue_rd_en, 0);
            tick();
        end
        qpush(2'd1, mk(2'd1, 8'd6, 8'd3), 1'b0);
        qpush(2'd1, mk(2'd1, 8'd6, 8'd4), 1'b1);
        exp_q.push_back({1'b0, mk(2'd1, 8'd6, 8'd3)});
        exp_q.push_back({1'b1, mk(2'd1, 8'd6, 8'd4)});
        expect_pkt(2'd3, 8'd6, 1);
        drain("ur_drain");

        // arb_en dropped mid-packet: packet completes, no new grant until re-enabled.
        pkt(2'd0, 8'd7, 4, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (queue_rd_en[0]) seen = 1'b1;
            else tick();
        end
        check("en_first_pop", seen, seen, 1);
        arb_en = 1'b0;
        pkt(2'd2, 8'd7, 2, 1'b1);
        for (int i = 0; i < 40 && exp_q.size() > 2; i++) tick();
        check("en_pkt_completed", exp_q.size() == 2, exp_q.size(), 2);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("en_no_grant_pop", queue_rd_en == 4'd0, queue_rd_en, 0);
            check("en_no_grant_valid", out_valid == 1'b0, out_valid, 0);
            tick();
        end
        arb_en = 1'b1;
        tick();
        check("en_regrant_pop", queue_rd_en == 4'b0100, queue_rd_en, 4'b0100);
        check("en_regrant_cur", cur_queue == 2'd2, cur_queue, 2);
        drain("en_drain");

        // Asynchronous reset mid-packet, then strict arbitration restarts cleanly.
        pkt(2'd2, 8'd9, 4, 1'b1);
        base = n_acc;
        for (int i = 0; i < 20 && n_acc == base; i++) tick();
        check("rst_mid_started", n_acc > base, n_acc - base, 1);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", out_valid == 1'b0, out_valid, 0);
        check("arst_rd_en", queue_rd_en == 4'd0, queue_rd_en, 0);
        check("arst_out_data", out_data == 32'd0, out_data, 0);
        check("arst_out_eop", out_eop == 1'b0, out_eop, 0);
        check("arst_cur_queue", cur_queue == 2'd0, cur_queue, 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        pkt(2'd1, 8'd10, 1, 1'b0);
        pkt(2'd0, 8'd10, 1, 1'b0);
        expect_pkt(2'd0, 8'd10, 1);
        expect_pkt(2'd1, 8'd10, 1);
        drain("post_reset_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
